// File: rtl/tdc_ctrl_pkg.sv
// Shared definitions for the TDC histogram sequencer.
//  - state_e : sequencer FSM states
//  - GPIO bit positions for the control (start/abort) and status (busy/done) words
//  - WE_ALL  : full-word BRAM byte-write enable
//  - sat_inc : saturating 32-bit increment used for histogram bins
package tdc_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    MCLR  = 4'd1,
    DLCLR = 4'd2,
    FIRE  = 4'd3,
    WAITE = 4'd4,
    RD    = 4'd5,
    WAITR = 4'd6,
    WR    = 4'd7,
    DONE  = 4'd8
  } state_e;

  localparam int START_B = 0;
  localparam int ABORT_B = 1;
  localparam int BUSY_B  = 0;
  localparam int DONE_B  = 1;

  localparam logic [3:0] WE_ALL = 4'hF;

  // A full bin stays full rather than wrapping to zero.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Two-flop synchroniser for one asynchronous GPIO bit, plus rising-edge detect.
// Ports:
//  clk, rst_n : clock, synchronous active-low reset
//  din        : asynchronous input bit
//  level      : synchronised level
//  rise       : one-cycle pulse on a synchronised 0->1 transition
module gpio_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level = sync_q;
  assign rise  = sync_q & ~prev_q;

endmodule

// File: rtl/tdc_hist_sequencer.sv
// TDC measurement sequencer. A GPIO start zeroes the 2**BIN_W-bin histogram in BRAM, then
// NSAMPLES times: pulse clear_o, pulse hit_o, wait for the encoder code, and read-modify-write
// bin[code] += 1 (saturating) through BRAM port B. busy/done are reported over GPIO.
// Ports:
//  clk, rst_n  : clock, synchronous active-low reset
//  ones        : encoder code, valid ENC_LAT cycles after hit_o
//  hit_o       : one-cycle hit pulse to the delay line
//  clear_o     : one-cycle clear pulse to the delay line
//  gpio2_io_o  : [0] start (rising edge), [1] abort (level); asynchronous
//  gpio_io_i   : [0] busy, [1] done
//  finish      : one-cycle pulse when a run completes
//  clkb, rstb, enb, web, addrb, datab, rd_data : BRAM port B
//  dbg_state   : current FSM state (tdc_ctrl_pkg::state_e encoding)
// Handshake: there is no backpressure. BRAM accepts one access per cycle when enb=1
// (web=WE_ALL write, web=0 read); read data is taken exactly RD_LAT cycles after the read.
// ENC_LAT and RD_LAT are assumed to be at least 1.
module tdc_hist_sequencer
  import tdc_ctrl_pkg::*;
#(
  parameter int BIN_W    = 8,
  parameter int NSAMPLES = 65536,
  parameter int ENC_LAT  = 3,
  parameter int RD_LAT   = 1,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BIN_W-1:0] ones,
  output logic             hit_o,
  output logic             clear_o,
  input  logic [1:0]       gpio2_io_o,
  output logic [1:0]       gpio_io_i,
  output logic             finish,
  output logic             clkb,
  output logic             rstb,
  output logic             enb,
  output logic [3:0]       web,
  output logic [14:0]      addrb,
  output logic [31:0]      datab,
  input  logic [31:0]      rd_data,
  output logic [3:0]       dbg_state
);

  localparam int  WAIT_W     = 8;
  localparam bit  NO_SAMPLES = (NSAMPLES == 0);

  state_e             state_q, state_d;
  logic [BIN_W-1:0]   bin_q;
  logic [BIN_W-1:0]   code_q;
  logic [CNT_W-1:0]   sample_q;
  logic [WAIT_W-1:0]  wait_q;
  logic [31:0]        rd_q;

  logic start_rise;
  logic abort_s;
  logic start_lvl_unused;
  logic abort_rise_unused;

  gpio_sync_edge u_sync_start (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (gpio2_io_o[START_B]),
    .level (start_lvl_unused),
    .rise  (start_rise)
  );

  gpio_sync_edge u_sync_abort (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (gpio2_io_o[ABORT_B]),
    .level (abort_s),
    .rise  (abort_rise_unused)
  );

  // Next-state logic. Abort wins over everything outside IDLE, and also blocks a start
  // seen in IDLE during the same cycle.
  always_comb begin
    state_d = state_q;
    if (state_q != IDLE && abort_s) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:  if (start_rise && !abort_s) state_d = MCLR;
        MCLR:  if (bin_q == '1) state_d = NO_SAMPLES ? DONE : DLCLR;
        DLCLR: state_d = FIRE;
        FIRE:  state_d = WAITE;
        WAITE: if (wait_q == WAIT_W'(ENC_LAT - 1)) state_d = RD;
        RD:    state_d = WAITR;
        WAITR: if (wait_q == WAIT_W'(RD_LAT - 1)) state_d = WR;
        WR:    state_d = (sample_q + CNT_W'(1) == CNT_W'(NSAMPLES)) ? DONE : DLCLR;
        DONE:  if (start_rise) state_d = MCLR;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      bin_q    <= '0;
      code_q   <= '0;
      sample_q <= '0;
      wait_q   <= '0;
      rd_q     <= '0;
      finish   <= 1'b0;
    end else begin
      state_q <= state_d;
      finish  <= (state_d == DONE) && (state_q != DONE);
      case (state_q)
        IDLE, DONE: begin
          if (state_d == MCLR) begin
            bin_q    <= '0;
            sample_q <= '0;
          end
        end
        MCLR:  bin_q  <= bin_q + 1'b1;
        FIRE:  wait_q <= '0;
        WAITE: begin
          wait_q <= wait_q + 1'b1;
          // The encoder code is valid only in the last wait cycle.
          if (state_d == RD) code_q <= ones;
        end
        RD:    wait_q <= '0;
        WAITR: begin
          wait_q <= wait_q + 1'b1;
          // Capture read data so WR does not depend on BRAM holding its output.
          if (state_d == WR) rd_q <= rd_data;
        end
        WR:    sample_q <= sample_q + 1'b1;
        default: ;
      endcase
    end
  end

  // Moore outputs. They are forced low while rst_n is asserted so that no BRAM write or
  // delay-line pulse escapes in the reset cycle itself.
  always_comb begin
    hit_o   = 1'b0;
    clear_o = 1'b0;
    enb     = 1'b0;
    web     = 4'h0;
    addrb   = '0;
    datab   = '0;
    if (rst_n) begin
      case (state_q)
        MCLR: begin
          enb   = 1'b1;
          web   = WE_ALL;
          addrb = 15'({bin_q, 2'b00});
        end
        DLCLR: clear_o = 1'b1;
        FIRE:  hit_o   = 1'b1;
        RD: begin
          enb   = 1'b1;
          addrb = 15'({code_q, 2'b00});
        end
        WR: begin
          enb   = 1'b1;
          web   = WE_ALL;
          addrb = 15'({code_q, 2'b00});
          datab = sat_inc(rd_q);
        end
        default: ;
      endcase
    end
  end

  assign gpio_io_i[BUSY_B] = (state_q != IDLE) && (state_q != DONE);
  assign gpio_io_i[DONE_B] = (state_q == DONE);
  assign clkb      = clk;
  assign rstb      = 1'b0;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_tdc_hist_sequencer.sv
module tb_tdc_hist_sequencer;
  import tdc_ctrl_pkg::*;

  localparam int NS         = 6;
  localparam int ENC_LAT    = 3;
  localparam int RD_LAT     = 1;
  localparam int NBINS      = 256;
  localparam int SAMPLE_CYC = 4 + ENC_LAT + RD_LAT;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- main DUT (NSAMPLES = NS) ----------------
  logic [7:0]  ones = 8'd0;
  logic        hit_o, clear_o, finish, clkb, rstb, enb;
  logic [1:0]  gpio2 = 2'b00;
  logic [1:0]  gpio_io_i;
  logic [3:0]  web, dbg_state;
  logic [14:0] addrb;
  logic [31:0] datab;
  logic [31:0] rd_data = 32'd0;

  tdc_hist_sequencer #(.BIN_W(8), .NSAMPLES(NS), .ENC_LAT(ENC_LAT), .RD_LAT(RD_LAT), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .ones(ones), .hit_o(hit_o), .clear_o(clear_o),
    .gpio2_io_o(gpio2), .gpio_io_i(gpio_io_i), .finish(finish), .clkb(clkb), .rstb(rstb),
    .enb(enb), .web(web), .addrb(addrb), .datab(datab), .rd_data(rd_data), .dbg_state(dbg_state)
  );

  // ---------------- clear-only DUT (NSAMPLES = 0) ----------------
  logic [7:0]  z_ones = 8'd0;
  logic        z_hit, z_clear, z_finish, z_clkb, z_rstb, z_enb;
  logic [1:0]  z_gpio2 = 2'b00;
  logic [1:0]  z_gpio_io_i;
  logic [3:0]  z_web, z_dbg;
  logic [14:0] z_addrb;
  logic [31:0] z_datab;
  logic [31:0] z_rd_data = 32'd0;

  tdc_hist_sequencer #(.BIN_W(8), .NSAMPLES(0), .ENC_LAT(ENC_LAT), .RD_LAT(RD_LAT), .CNT_W(32)) dut0 (
    .clk(clk), .rst_n(rst_n), .ones(z_ones), .hit_o(z_hit), .clear_o(z_clear),
    .gpio2_io_o(z_gpio2), .gpio_io_i(z_gpio_io_i), .finish(z_finish), .clkb(z_clkb), .rstb(z_rstb),
    .enb(z_enb), .web(z_web), .addrb(z_addrb), .datab(z_datab), .rd_data(z_rd_data), .dbg_state(z_dbg)
  );

  // ---------------- BRAM model (1-cycle read latency) ----------------
  logic [31:0] mem [NBINS];
  logic        preload_req = 1'b0;
  logic        sat_en = 1'b0;
  logic [7:0]  sat_bin = 8'd0;

  always @(posedge clk) begin
    if (preload_req) begin
      for (int i = 0; i < NBINS; i++) mem[i] <= $urandom;
    end else if (enb) begin
      if (web == 4'hF) mem[addrb[9:2]] <= datab;
      else if (web == 4'h0)
        rd_data <= (sat_en && addrb[9:2] == sat_bin) ? 32'hFFFF_FFFF : mem[addrb[9:2]];
    end
  end

  // ---------------- encoder model ----------------
  // The planned code is presented only in the cycle exactly ENC_LAT after hit_o; every
  // other cycle carries random garbage.
  logic [7:0] code_tbl [64];
  int         hit_total = 0;
  int         age = 99;
  logic [7:0] cur_code = 8'd0;

  always @(negedge clk) begin
    if (hit_o) begin
      cur_code = code_tbl[hit_total % 64];
      hit_total++;
      age = 0;
    end else if (age < 99) begin
      age++;
    end
    ones = (age == ENC_LAT) ? cur_code : 8'($urandom);
  end

  // ---------------- bus monitor ----------------
  int          cyc = 0, proto_err = 0, gap_err = 0, finish_total = 0;
  int          mclr_total = 0, rmw_total = 0, rd_total = 0, hits = 0, last_hit = -1000;
  logic        pend = 1'b0, prev_clear = 1'b0;
  logic [14:0] pend_addr = 15'd0;
  logic [31:0] obs_data [$];
  logic [7:0]  obs_bin [$];
  int          hit_mclr [64];

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      pend = 1'b0;
      prev_clear = 1'b0;
    end else begin
      if (hit_o && clear_o) proto_err++;
      if (hit_o) begin
        if (!prev_clear) proto_err++;
        if (cyc - last_hit < 20 && cyc - last_hit != SAMPLE_CYC) gap_err++;
        last_hit = cyc;
        hit_mclr[hits % 64] = mclr_total;
        hits++;
      end
      if (enb && web == 4'h0) begin
        if (pend) proto_err++;
        pend = 1'b1;
        pend_addr = addrb;
        rd_total++;
      end else if (enb && web == 4'hF) begin
        if (pend) begin
          if (addrb !== pend_addr) proto_err++;
          obs_data.push_back(datab);
          obs_bin.push_back(addrb[9:2]);
          rmw_total++;
          pend = 1'b0;
        end else begin
          if (datab !== 32'd0) proto_err++;
          mclr_total++;
        end
      end else if (enb) begin
        proto_err++;
      end
      if (finish) finish_total++;
      prev_clear = clear_o;
    end
  end

  // ---------------- reference model / scoreboard ----------------
  logic [31:0] exp_q [$];
  logic [7:0]  exp_bin_q [$];
  int          exp_hist [NBINS];

  // mode 0: every sample hits 'base'; mode 1: alternate 5/6; mode 2: base + random 0..3
  task automatic plan_run(input int mode, input logic [7:0] base);
    int h0;
    h0 = hit_total;
    exp_q.delete();
    exp_bin_q.delete();
    for (int b = 0; b < NBINS; b++) exp_hist[b] = 0;
    for (int k = 0; k < NS; k++) begin
      logic [7:0] c;
      case (mode)
        0:       c = base;
        1:       c = (k % 2 == 0) ? 8'd5 : 8'd6;
        default: c = base + 8'($urandom_range(0, 3));
      endcase
      code_tbl[(h0 + k) % 64] = c;
      exp_hist[c]++;
      exp_bin_q.push_back(c);
      exp_q.push_back((sat_en && c == sat_bin) ? 32'hFFFF_FFFF : 32'(exp_hist[c]));
    end
  endtask

  function automatic int hist_bad();
    int bad = 0;
    for (int b = 0; b < NBINS; b++) begin
      logic [31:0] e;
      e = (exp_hist[b] == 0) ? 32'd0 :
          (sat_en && b == int'(sat_bin)) ? 32'hFFFF_FFFF : 32'(exp_hist[b]);
      if (mem[b] !== e) bad++;
    end
    return bad;
  endfunction

  function automatic int obs_bad(input int base);
    int bad = 0;
    for (int k = 0; k < NS && base + k < obs_data.size(); k++)
      if (obs_data[base + k] !== exp_q[k] || obs_bin[base + k] !== exp_bin_q[k]) bad++;
    return bad;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    gpio2[START_B] = 1'b1;
    tick(4);
    gpio2[START_B] = 1'b0;
    tick(4);
  endtask

  task automatic wait_finish(input int f0, output bit ok);
    int n = 0;
    while (finish_total == f0 && n < 3000) begin
      tick(1);
      n++;
    end
    ok = (finish_total != f0);
  endtask

  task automatic preload();
    preload_req = 1'b1;
    tick(1);
    preload_req = 1'b0;
    tick(1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    n_cmp++;
    if ({hit_o, clear_o, enb, finish} !== 4'b0) begin
      n_bad++; $display("FAIL reset_pulses: got %b want 0000", {hit_o, clear_o, enb, finish});
    end
    n_cmp++;
    if ({web, addrb, datab} !== '0) begin
      n_bad++; $display("FAIL reset_bram: web=%h addr=%h data=%h want 0", web, addrb, datab);
    end
    n_cmp++;
    if (gpio_io_i !== 2'b00 || z_gpio_io_i !== 2'b00) begin
      n_bad++; $display("FAIL reset_gpio: got %b/%b want 00", gpio_io_i, z_gpio_io_i);
    end
    n_cmp++;
    if (dbg_state !== 4'(IDLE) || rstb !== 1'b0) begin
      n_bad++; $display("FAIL reset_state: state=%0d rstb=%b want %0d/0", dbg_state, rstb, IDLE);
    end
    rst_n = 1'b1;
    tick(3);
  endtask

  task automatic test_clear_only();
    int idx = 0, bad = 0, fins = 0, n = 0, pulses = 0;
    z_gpio2[START_B] = 1'b1;
    while (n < 2000 && !(fins > 0 && n > 300)) begin
      tick(1);
      n++;
      if (n == 4) z_gpio2[START_B] = 1'b0;
      if (z_enb) begin
        if (z_web !== 4'hF || z_addrb !== 15'(idx * 4) || z_datab !== 32'd0) bad++;
        idx++;
      end
      if (z_hit || z_clear) pulses++;
      if (z_finish) fins++;
    end
    n_cmp++;
    if (fins != 1) begin n_bad++; $display("FAIL clr_finish: got %0d pulses want 1", fins); end
    n_cmp++;
    if (idx != NBINS) begin n_bad++; $display("FAIL clr_count: got %0d writes want %0d", idx, NBINS); end
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL clr_writes: %0d bad writes want 0", bad); end
    n_cmp++;
    if (pulses != 0) begin n_bad++; $display("FAIL clr_pulses: got %0d hit/clear want 0", pulses); end
    n_cmp++;
    if (z_gpio_io_i !== 2'b10) begin n_bad++; $display("FAIL clr_gpio: got %b want 10", z_gpio_io_i); end
  endtask

  // Full run against the reference model; label distinguishes the scenario in messages.
  task automatic test_hist(input string label, input int mode, input logic [7:0] base);
    int f0, h0, m0, ob, p0, g0;
    bit ok;
    preload();
    plan_run(mode, base);
    f0 = finish_total; h0 = hits; m0 = mclr_total; ob = obs_data.size();
    p0 = proto_err; g0 = gap_err;
    pulse_start();
    wait_finish(f0, ok);
    tick(5);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL %s_timeout: no finish within budget", label); end
    n_cmp++;
    if (finish_total - f0 != 1) begin
      n_bad++; $display("FAIL %s_finish: got %0d pulses want 1", label, finish_total - f0);
    end
    n_cmp++;
    if (hits - h0 != NS || obs_data.size() - ob != NS) begin
      n_bad++; $display("FAIL %s_counts: hits=%0d rmw=%0d want %0d", label, hits - h0, obs_data.size() - ob, NS);
    end
    n_cmp++;
    if (mclr_total - m0 != NBINS) begin
      n_bad++; $display("FAIL %s_mclr: got %0d clears want %0d", label, mclr_total - m0, NBINS);
    end
    n_cmp++;
    if (obs_bad(ob) != 0) begin
      n_bad++; $display("FAIL %s_rmw_data: %0d writes differ from model", label, obs_bad(ob));
    end
    n_cmp++;
    if (hist_bad() != 0) begin
      n_bad++; $display("FAIL %s_hist: %0d bins differ from model", label, hist_bad());
    end
    n_cmp++;
    if (proto_err != p0 || gap_err != g0) begin
      n_bad++; $display("FAIL %s_protocol: proto=%0d gap=%0d want 0/0", label, proto_err - p0, gap_err - g0);
    end
    n_cmp++;
    if (gpio_io_i !== 2'b10) begin n_bad++; $display("FAIL %s_gpio: got %b want 10", label, gpio_io_i); end
  endtask

  task automatic test_abort();
    int r0, n = 0, w0, h0, f0, q0;
    plan_run(2, 8'd100);
    r0 = rd_total; q0 = rmw_total; f0 = finish_total;
    pulse_start();
    while (rd_total - r0 < 2 && n < 2000) begin tick(1); n++; end
    tick(1);                       // now in WAITR of sample 2
    gpio2[ABORT_B] = 1'b1;
    n = 0;
    while (dbg_state !== 4'(IDLE) && n < 10) begin tick(1); n++; end
    n_cmp++;
    if (n > 3) begin n_bad++; $display("FAIL abort_latency: got %0d cycles want <=3", n); end
    w0 = mclr_total + rmw_total; h0 = hits;
    tick(30);
    n_cmp++;
    if (mclr_total + rmw_total != w0 || hits != h0) begin
      n_bad++; $display("FAIL abort_quiet: %0d writes %0d hits after abort want 0/0",
                        mclr_total + rmw_total - w0, hits - h0);
    end
    n_cmp++;
    if (rmw_total - q0 != 2) begin n_bad++; $display("FAIL abort_rmw: got %0d want 2", rmw_total - q0); end
    n_cmp++;
    if (gpio_io_i !== 2'b00 || finish_total != f0) begin
      n_bad++; $display("FAIL abort_status: gpio=%b finish=%0d want 00/0", gpio_io_i, finish_total - f0);
    end
    gpio2[ABORT_B] = 1'b0;
    tick(5);
  endtask

  task automatic test_reset_midrun();
    int n = 0, f0;
    plan_run(2, 8'($urandom_range(0, 250)));
    f0 = finish_total;
    pulse_start();
    while (!(enb && web == 4'hF && dbg_state == 4'(WR)) && n < 2000) begin tick(1); n++; end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (enb !== 1'b0 || web !== 4'h0) begin
      n_bad++; $display("FAIL rst_mid_write: enb=%b web=%h want 0/0", enb, web);
    end
    tick(2);
    n_cmp++;
    if (dbg_state !== 4'(IDLE) || gpio_io_i !== 2'b00 || finish_total != f0) begin
      n_bad++; $display("FAIL rst_mid_state: state=%0d gpio=%b want %0d/00", dbg_state, gpio_io_i, IDLE);
    end
    rst_n = 1'b1;
    tick(3);
  endtask

  task automatic test_back_to_back();
    int f0, h0, n = 0, ob;
    bit ok, saw;
    // Run with start toggled while busy: the toggles must not add runs.
    plan_run(2, 8'($urandom_range(0, 250)));
    f0 = finish_total; h0 = hits;
    pulse_start();
    tick(20);
    pulse_start();                 // during memory clear
    while (hits - h0 < 2 && n < 2000) begin tick(1); n++; end
    pulse_start();                 // during sampling
    wait_finish(f0, ok);
    tick(40);
    n_cmp++;
    if (!ok || finish_total - f0 != 1 || hist_bad() != 0) begin
      n_bad++; $display("FAIL busy_start: finishes=%0d bad_bins=%0d want 1/0", finish_total - f0, hist_bad());
    end
    // Start in DONE restarts: done drops and memory is re-zeroed before the first hit.
    plan_run(1, 8'd0);
    f0 = finish_total; h0 = hits; ob = obs_data.size();
    gpio2[START_B] = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (gpio_io_i === 2'b01) saw = 1'b1;
    end
    gpio2[START_B] = 1'b0;
    n_cmp++;
    if (!saw) begin n_bad++; $display("FAIL restart_gpio: got %b want 01", gpio_io_i); end
    wait_finish(f0, ok);
    tick(3);
    n_cmp++;
    if (!ok || hit_mclr[h0 % 64] - (hit_mclr[h0 % 64] - NBINS) != NBINS ||
        mclr_total - hit_mclr[h0 % 64] != 0) begin
      n_bad++; $display("FAIL restart_order: timeout=%0b clears after first hit=%0d want 0/0",
                        !ok, mclr_total - hit_mclr[h0 % 64]);
    end
    n_cmp++;
    if (obs_bad(ob) != 0 || hist_bad() != 0 || mem[5] !== 32'd3 || mem[6] !== 32'd3) begin
      n_bad++; $display("FAIL restart_hist: bin5=%0d bin6=%0d want 3/3", mem[5], mem[6]);
    end
  endtask

  // ---------------- main sequence + report ----------------
  initial begin
    for (int i = 0; i < 64; i++) code_tbl[i] = 8'd0;
    test_reset();
    test_clear_only();
    test_hist("single37", 0, 8'd37);
    n_cmp++;
    if (mem[37] !== 32'd6) begin n_bad++; $display("FAIL single37_word: got %0d want 6", mem[37]); end
    test_hist("alt56", 1, 8'd0);
    test_hist("random", 2, 8'($urandom_range(0, 252)));
    sat_en = 1'b1;
    sat_bin = 8'd200;
    test_hist("saturate", 0, 8'd200);
    sat_en = 1'b0;
    test_abort();
    test_reset_midrun();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
